// File: rtl/lcd_timing_pkg.sv
// Shared constants, state encoding and panel-signal bundle for the 480x272 LCD timing generator.
package lcd_timing_pkg;

    localparam int unsigned H_ACTIVE_DEF    = 480;
    localparam int unsigned H_FP_DEF        = 8;
    localparam int unsigned H_SYNC_DEF      = 4;
    localparam int unsigned H_BP_DEF        = 43;
    localparam int unsigned V_ACTIVE_DEF    = 272;
    localparam int unsigned V_FP_DEF        = 4;
    localparam int unsigned V_SYNC_DEF      = 4;
    localparam int unsigned V_BP_DEF        = 12;
    localparam int unsigned LOCK_STABLE_DEF = 16;
    localparam int unsigned CW_DEF          = 10;

    function automatic int unsigned line_total(input int unsigned act, input int unsigned fp,
                                               input int unsigned sync, input int unsigned bp);
        return act + fp + sync + bp;
    endfunction

    localparam int unsigned H_TOTAL_DEF = line_total(H_ACTIVE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);
    localparam int unsigned V_TOTAL_DEF = line_total(V_ACTIVE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        SETTLE    = 2'd1,
        RUN       = 2'd2
    } lcd_state_e;

    // Panel-facing controls; syncs are active-low.
    typedef struct packed {
        logic de;
        logic hsync;
        logic vsync;
        logic line_start;
        logic frame_start;
    } panel_sig_t;

    localparam panel_sig_t PANEL_IDLE = '{de: 1'b0, hsync: 1'b1, vsync: 1'b1,
                                          line_start: 1'b0, frame_start: 1'b0};

endpackage

// File: rtl/pll_lock_filter.sv
// Qualifies the rPLL lock: lock_ok rises once lock has been high for LOCK_STABLE consecutive clocks
// and drops on the first edge at which lock is sampled low.
module pll_lock_filter
    import lcd_timing_pkg::*;
#(
    parameter int unsigned LOCK_STABLE = LOCK_STABLE_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pll_lock,
    output logic lock_ok
);

    localparam int unsigned LW = $clog2(LOCK_STABLE + 1);

    lcd_state_e    state_q;
    logic [LW-1:0] cnt_q;
    logic          lock_ok_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= WAIT_LOCK;
            cnt_q     <= '0;
            lock_ok_q <= 1'b0;
        end else begin
            case (state_q)
                WAIT_LOCK: begin
                    cnt_q <= '0;
                    if (pll_lock) begin
                        cnt_q <= LW'(1);
                        if (LOCK_STABLE <= 1) begin
                            state_q   <= RUN;
                            lock_ok_q <= 1'b1;
                        end else begin
                            state_q <= SETTLE;
                        end
                    end
                end
                SETTLE: begin
                    if (!pll_lock) begin
                        state_q <= WAIT_LOCK;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + LW'(1);
                        // This edge is the LOCK_STABLE-th consecutive high sample.
                        if (cnt_q == LW'(LOCK_STABLE - 1)) begin
                            state_q   <= RUN;
                            lock_ok_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (!pll_lock) begin
                        state_q   <= WAIT_LOCK;
                        cnt_q     <= '0;
                        lock_ok_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= WAIT_LOCK;
                    cnt_q     <= '0;
                    lock_ok_q <= 1'b0;
                end
            endcase
        end
    end

    assign lock_ok = lock_ok_q;

endmodule

// File: rtl/lcd_timing_gen.sv
// Raster counters plus a two-stage pipeline: a request stage one cycle ahead of the panel stage
// so a 1-cycle-latency pixel source lines up with lcd_de.
module lcd_timing_gen
    import lcd_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE    = H_ACTIVE_DEF,
    parameter int unsigned H_FP        = H_FP_DEF,
    parameter int unsigned H_SYNC      = H_SYNC_DEF,
    parameter int unsigned H_BP        = H_BP_DEF,
    parameter int unsigned V_ACTIVE    = V_ACTIVE_DEF,
    parameter int unsigned V_FP        = V_FP_DEF,
    parameter int unsigned V_SYNC      = V_SYNC_DEF,
    parameter int unsigned V_BP        = V_BP_DEF,
    parameter int unsigned LOCK_STABLE = LOCK_STABLE_DEF,
    parameter int unsigned CW          = CW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pll_lock,
    output logic          running,
    output logic          req_valid,
    output logic [CW-1:0] req_x,
    output logic [CW-1:0] req_y,
    output logic          lcd_de,
    output logic          lcd_hsync,
    output logic          lcd_vsync,
    output logic          line_start,
    output logic          frame_start
);

    localparam int unsigned H_TOTAL  = line_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL  = line_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;

    logic          lock_ok;
    logic          run_c;
    logic [CW-1:0] h_q, h_d, v_q, v_d;
    logic [CW-1:0] req_x_q, req_x_d, req_y_q, req_y_d;
    panel_sig_t    req_q, req_d, disp_q, disp_d;

    pll_lock_filter #(.LOCK_STABLE(LOCK_STABLE)) u_lock_filter (
        .clk      (clk),
        .rst_n    (rst_n),
        .pll_lock (pll_lock),
        .lock_ok  (lock_ok)
    );

    // Lock loss is acted on at the same edge the filter leaves RUN.
    assign run_c = lock_ok && pll_lock;

    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (!run_c) begin
            h_d = '0;
            v_d = '0;
        end else if (h_q == CW'(H_TOTAL - 1)) begin
            h_d = '0;
            v_d = (v_q == CW'(V_TOTAL - 1)) ? '0 : v_q + CW'(1);
        end else begin
            h_d = h_q + CW'(1);
        end
    end

    always_comb begin
        req_d   = PANEL_IDLE;
        req_x_d = req_x_q;
        req_y_d = req_y_q;
        disp_d  = PANEL_IDLE;
        if (run_c) begin
            req_d.de          = (h_q < CW'(H_ACTIVE)) && (v_q < CW'(V_ACTIVE));
            req_d.hsync       = !((h_q >= CW'(HS_START)) && (h_q < CW'(HS_END)));
            req_d.vsync       = !((v_q >= CW'(VS_START)) && (v_q < CW'(VS_END)));
            req_d.line_start  = (h_q == '0) && (v_q < CW'(V_ACTIVE));
            req_d.frame_start = (h_q == '0) && (v_q == '0);
            if (req_d.de) begin
                req_x_d = h_q;
                req_y_d = v_q;
            end
            disp_d = req_q;
        end else begin
            req_x_d = '0;
            req_y_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q     <= '0;
            v_q     <= '0;
            req_q   <= PANEL_IDLE;
            req_x_q <= '0;
            req_y_q <= '0;
            disp_q  <= PANEL_IDLE;
        end else begin
            h_q     <= h_d;
            v_q     <= v_d;
            req_q   <= req_d;
            req_x_q <= req_x_d;
            req_y_q <= req_y_d;
            disp_q  <= disp_d;
        end
    end

    assign running     = lock_ok;
    assign req_valid   = req_q.de;
    assign req_x       = req_x_q;
    assign req_y       = req_y_q;
    assign lcd_de      = disp_q.de;
    assign lcd_hsync   = disp_q.hsync;
    assign lcd_vsync   = disp_q.vsync;
    assign line_start  = disp_q.line_start;
    assign frame_start = disp_q.frame_start;

endmodule

// File: doc/lcd_timing_gen.md
# lcd_timing_gen

Video timing generator for the 480x272 RGB LCD panel. Runs in the 9 MHz pixel clock domain produced by the on-chip rPLL and consumes that PLL's `lock` output. Holds the panel idle until lock has been stable, then produces hsync/vsync/de plus a one-cycle-early pixel request (x, y) so a 1-cycle-latency framebuffer or pattern source lines up with `de`.

## Interface
- `H_ACTIVE`, 480: visible pixels per line
- `H_FP`, 8: horizontal front porch (clocks)
- `H_SYNC`, 4: hsync pulse width (clocks)
- `H_BP`, 43: horizontal back porch (clocks); H_TOTAL = 535
- `V_ACTIVE`, 272: visible lines per frame
- `V_FP`, 4 / `V_SYNC`, 4 / `V_BP`, 12: vertical porches/pulse (lines); V_TOTAL = 292
- `LOCK_STABLE`, 16: consecutive lock-high cycles required before starting
- `CW`, 10: coordinate/counter width; must satisfy 2^CW >= max(H_TOTAL, V_TOTAL)
- `clk` in 1: 9 MHz pixel clock (rPLL `clkout`)
- `rst_n` in 1: asynchronous, active-low reset
- `pll_lock` in 1: rPLL `lock`; treated as synchronous to `clk`
- `running` out 1: high while in RUN
- `req_valid` out 1: pixel request; precedes `de` by exactly 1 cycle
- `req_x`, `req_y` out CW: coordinates of requested pixel
- `lcd_de` out 1: data enable
- `lcd_hsync`, `lcd_vsync` out 1: active-low syncs
- `line_start` out 1: 1-cycle pulse with first `de` of each active line
- `frame_start` out 1: 1-cycle pulse with `de` of pixel (0,0)

## Operation
- States: WAIT_LOCK (reset state) -> SETTLE -> RUN.
- WAIT_LOCK: lock counter = 0; if `pll_lock`=1, go to SETTLE with counter = 1.
- SETTLE: `pll_lock`=1 increments counter; when counter reaches LOCK_STABLE go to RUN. `pll_lock`=0 returns to WAIT_LOCK, counter cleared.
- RUN: h_cnt counts 0..H_TOTAL-1 and wraps; v_cnt increments on h wrap, 0..V_TOTAL-1 and wraps. Both are 0 on RUN entry.
- Line order: active [0, H_ACTIVE), front porch, sync [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), back porch. Vertical identical in lines; vsync changes at h_cnt wrap.
- Request stage (registered from counters): `req_valid` = h_cnt<H_ACTIVE && v_cnt<V_ACTIVE; `req_x`/`req_y` = h_cnt/v_cnt when valid, else hold last value.
- Display stage (registered from request stage): `lcd_de` = prior `req_valid`; hsync/vsync likewise delayed so all panel outputs are mutually aligned.
- `pll_lock`=0 in RUN: next state WAIT_LOCK, counters cleared, both pipeline stages forced to reset values on the same edge; restart always begins at pixel (0,0) after a full LOCK_STABLE settle.

## Timing
- Reset values (async, immediate): running=0, req_valid=0, req_x=req_y=0, lcd_de=0, lcd_hsync=1, lcd_vsync=1, line_start=0, frame_start=0; state WAIT_LOCK.
- `running` rises on the edge entering RUN; `req_valid` with (0,0) rises 1 cycle later; `lcd_de`/`frame_start` 1 cycle after that.
- Line period 535 clocks: de high 480, hsync low 4, hsync falls 488 clocks after de rises.
- Frame period 535*292 = 156220 clocks; vsync low 4 lines = 2140 clocks, falls/rises aligned with hsync-stage h wrap.
- Lock loss: outputs inactive on the first edge at which `pll_lock`=0 is sampled; no partial-frame completion.

## Structure
- Package `lcd_timing_pkg`: default porch/active constants, H_TOTAL/V_TOTAL derivation, state enum (WAIT_LOCK, SETTLE, RUN).
- Sub-module `pll_lock_filter`: WAIT_LOCK/SETTLE counter, outputs a single `lock_ok` level; top level holds the counters and the two pipeline stages.

## Test plan
- Reset, then `pll_lock`=1 held -> `running` rises exactly 16 edges after lock first sampled; req (0,0) 1 cycle later; `lcd_de`+`frame_start` 1 cycle after that.
- Free run one line -> de high 480 clocks, hsync low exactly 4, hsync fall 488 after de rise, period 535.
- Free run two frames -> `frame_start` spacing 156220 clocks; vsync low 2140 clocks; 272 `line_start` pulses per frame; last req (479,271).
- Lock toggling 1,1,1,0 during SETTLE -> stays off; settle restarts, `running` rises 16 edges after the last rise.
- `pll_lock` low 1 cycle during line 100 of RUN -> next edge de=0, hsync=vsync=1, running=0; after relock, first req is (0,0).
- Assert `rst_n`=0 mid-active-line without clock edge -> all outputs at reset values immediately; release -> WAIT_LOCK.
